// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - packet-level round-robin arbiter in front of a UART TX FIFO write port
//
// Grants one requester per packet and forwards its bytes to the TX FIFO so
// packets never interleave on the serial line. A grant ends on a last beat or
// is force-released after MAX_PKT beats (trunc_o pulses on that beat).
//
// Optional feature macro: UART_ARB_ID_HDR_EN
//   When defined, every grant first writes the owner index (zero-extended)
//   as a one-byte header before the packet bytes.
//
// Ports:
//   clk_i        system clock, rising edge
//   rst_ni       asynchronous active-low reset
//   req_valid_i  per-requester byte valid
//   req_data_i   per-requester byte, requester k at [k*DATA_WIDTH +: DATA_WIDTH]
//   req_last_i   per-requester end-of-packet flag, qualified by valid
//   req_ready_o  per-requester accept
//   fifo_full_i  TX FIFO full
//   fifo_wen_o   TX FIFO write enable
//   fifo_din_o   TX FIFO write data (0 when not writing)
//   grant_o      one-hot current owner, 0 when idle
//   busy_o       a grant is active
//   trunc_o      pulse on the beat that force-releases a grant at MAX_PKT
module uart_tx_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_PKT    = 64
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic [NUM_REQ-1:0]            req_valid_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_i,
  input  logic [NUM_REQ-1:0]            req_last_i,
  output logic [NUM_REQ-1:0]            req_ready_o,
  input  logic                          fifo_full_i,
  output logic                          fifo_wen_o,
  output logic [DATA_WIDTH-1:0]         fifo_din_o,
  output logic [NUM_REQ-1:0]            grant_o,
  output logic                          busy_o,
  output logic                          trunc_o
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(MAX_PKT + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MAX_PKT - 1);
  localparam logic [IDX_W-1:0] TOP_IDX  = IDX_W'(NUM_REQ - 1);

`ifdef UART_ARB_ID_HDR_EN
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_HDR = 2'd1, S_XFER = 2'd2} state_t;

  // The header byte carries the owner index, so it must fit in a data word.
  if (DATA_WIDTH < $clog2(NUM_REQ)) begin : g_hdr_width_check
    $error("uart_tx_arbiter: DATA_WIDTH too narrow for the owner index header");
  end
`else
  typedef enum logic {S_IDLE = 1'b0, S_XFER = 1'b1} state_t;
`endif

  state_t               state_q, state_d;
  logic [IDX_W-1:0]     rr_q, rr_d;
  logic [IDX_W-1:0]     owner_q, owner_d;
  logic [NUM_REQ-1:0]   grant_q, grant_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;

  logic [IDX_W-1:0]     sel_idx;
  logic                 own_valid;
  logic                 own_last;
  logic [DATA_WIDTH-1:0] own_data;
  logic                 accept;

  assign own_valid = req_valid_i[owner_q];
  assign own_last  = req_last_i[owner_q];
  assign own_data  = req_data_i[int'(owner_q)*DATA_WIDTH +: DATA_WIDTH];

  assign grant_o = grant_q;
  assign busy_o  = (state_q != S_IDLE);

  // Round-robin pick: walk downward over offsets so the smallest offset from
  // the pointer (the first valid requester at or after rr_q) wins.
  always_comb begin
    sel_idx = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      automatic int c = int'(rr_q) + i;
      if (c >= NUM_REQ) c = c - NUM_REQ;
      if (req_valid_i[c]) sel_idx = IDX_W'(c);
    end
  end

  always_comb begin
    state_d     = state_q;
    rr_d        = rr_q;
    owner_d     = owner_q;
    grant_d     = grant_q;
    cnt_d       = cnt_q;
    req_ready_o = '0;
    fifo_wen_o  = 1'b0;
    fifo_din_o  = '0;
    trunc_o     = 1'b0;
    accept      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (|req_valid_i) begin
          owner_d = sel_idx;
          grant_d = NUM_REQ'(1) << sel_idx;
          cnt_d   = '0;
`ifdef UART_ARB_ID_HDR_EN
          state_d = S_HDR;
`else
          state_d = S_XFER;
`endif
        end
      end
`ifdef UART_ARB_ID_HDR_EN
      S_HDR: begin
        if (!fifo_full_i) begin
          fifo_wen_o = 1'b1;
          fifo_din_o = DATA_WIDTH'(owner_q);
          state_d    = S_XFER;
        end
      end
`endif
      S_XFER: begin
        req_ready_o[owner_q] = !fifo_full_i;
        accept = own_valid && !fifo_full_i;
        if (accept) begin
          fifo_wen_o = 1'b1;
          fifo_din_o = own_data;
          cnt_d      = cnt_q + 1'b1;
          // Release on a last beat, or force-release once the beat limit is hit.
          if (own_last || (cnt_q == LAST_CNT)) begin
            trunc_o = !own_last;
            state_d = S_IDLE;
            grant_d = '0;
            rr_d    = (owner_q == TOP_IDX) ? '0 : owner_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      rr_q    <= '0;
      owner_q <= '0;
      grant_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      owner_q <= owner_d;
      grant_q <= grant_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - self-checking bench for uart_tx_arbiter
`timescale 1ns/1ps
module tb_uart_tx_arbiter;
  localparam int N  = 4;
  localparam int W  = 8;
  localparam int MP = 4;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   req_valid, req_last, req_ready, grant;
  logic [N*W-1:0] req_data;
  logic           fifo_full, fifo_wen, busy, trunc;
  logic [W-1:0]   fifo_din;

  uart_tx_arbiter #(.NUM_REQ(N), .DATA_WIDTH(W), .MAX_PKT(MP)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .req_valid_i(req_valid), .req_data_i(req_data), .req_last_i(req_last),
    .req_ready_o(req_ready), .fifo_full_i(fifo_full),
    .fifo_wen_o(fifo_wen), .fifo_din_o(fifo_din),
    .grant_o(grant), .busy_o(busy), .trunc_o(trunc)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0] grant, valid, ready;
    logic         wen, trunc, full, busy;
    logic [W-1:0] din;
  } cyc_t;

  cyc_t         log_q[$];
  logic [W:0]   src_q[N][$];     // {last, data} per requester
  logic [W+1:0] exp_q[N][$];     // {trunc, chunk_end, data} per requester
  int           valid_pct  = 100;
  int           full_pct   = 0;
  bit           full_force = 1'b0;
  bit           log_en     = 1'b0;
  logic [N-1:0] acc;
  int           errors = 0;
  int           checks = 0;

  // Requester sources and FIFO-full generator: drive just after each rising edge.
  initial begin : driver
    logic [W:0] b;
    req_valid = '0; req_data = '0; req_last = '0; fifo_full = 1'b0; acc = '0;
    forever begin
      @(posedge clk); #1;
      for (int k = 0; k < N; k++) begin
        if (acc[k] && src_q[k].size() > 0) void'(src_q[k].pop_front());
        if (src_q[k].size() > 0 && int'($urandom_range(99)) < valid_pct) begin
          b = src_q[k][0];
          req_valid[k] = 1'b1;
          req_data[k*W +: W] = b[W-1:0];
          req_last[k] = b[W];
        end else begin
          req_valid[k] = 1'b0;
          req_data[k*W +: W] = W'($urandom);
          req_last[k] = 1'($urandom);
        end
      end
      acc = '0;
      fifo_full = full_force || (int'($urandom_range(99)) < full_pct);
    end
  end

  // Cycle recorder: samples mid-cycle on the falling edge.
  initial begin : monitor
    cyc_t c;
    forever begin
      @(negedge clk);
      acc = req_valid & req_ready;
      if (log_en) begin
        c.grant = grant; c.valid = req_valid; c.ready = req_ready;
        c.wen = fifo_wen; c.trunc = trunc; c.full = fifo_full; c.busy = busy;
        c.din = fifo_din;
        log_q.push_back(c);
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic run(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic start_log();
    @(posedge clk); #2;
    log_q.delete();
    log_en = 1'b1;
  endtask

  task automatic do_reset();
    @(posedge clk); #2;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    checks++; if (grant !== '0)     begin errors++; $display("FAIL reset_grant: got %b expected 0", grant); end
    checks++; if (busy !== 1'b0)    begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (trunc !== 1'b0)   begin errors++; $display("FAIL reset_trunc: got %b expected 0", trunc); end
    checks++; if (fifo_wen !== 1'b0) begin errors++; $display("FAIL reset_wen: got %b expected 0", fifo_wen); end
    checks++; if (req_ready !== '0) begin errors++; $display("FAIL reset_ready: got %b expected 0", req_ready); end
    checks++; if (fifo_din !== '0)  begin errors++; $display("FAIL reset_din: got %h expected 0", fifo_din); end
    @(posedge clk); #2 rst_n = 1'b1;
    run(2);
    checks++; if (grant !== '0)     begin errors++; $display("FAIL reset_idle_grant: got %b expected 0", grant); end
  endtask

  task automatic test_single();
    logic [W-1:0] exp_d[3];
    int i0;
    exp_d = '{8'h11, 8'h22, 8'h33};
    start_log();
    src_q[0].push_back({1'b0, 8'h11});
    src_q[0].push_back({1'b0, 8'h22});
    src_q[0].push_back({1'b1, 8'h33});
    run(10);
    log_en = 1'b0;
    i0 = -1;
    for (int t = 0; t < log_q.size(); t++) if (i0 < 0 && log_q[t].valid[0]) i0 = t;
    checks++;
    if (i0 < 0 || i0 + 4 >= log_q.size()) begin
      errors++; $display("FAIL single_valid_seen: got index %0d expected a valid cycle", i0);
    end else begin
      checks++; if (log_q[i0].grant !== 4'b0000) begin errors++; $display("FAIL single_arb_cycle: got %b expected 0000", log_q[i0].grant); end
      checks++; if (log_q[i0+1].grant !== 4'b0001) begin errors++; $display("FAIL single_grant: got %b expected 0001", log_q[i0+1].grant); end
      for (int j = 0; j < 3; j++) begin
        checks++;
        if (log_q[i0+1+j].wen !== 1'b1 || log_q[i0+1+j].din !== exp_d[j]) begin
          errors++; $display("FAIL single_byte%0d: got wen=%b din=%h expected wen=1 din=%h", j, log_q[i0+1+j].wen, log_q[i0+1+j].din, exp_d[j]);
        end
      end
      checks++; if (log_q[i0+4].grant !== '0 || log_q[i0+4].busy !== 1'b0) begin errors++; $display("FAIL single_release: got grant=%b busy=%b expected 0/0", log_q[i0+4].grant, log_q[i0+4].busy); end
    end
  endtask

  task automatic test_rr();
    logic [W-1:0] exp_d[5];
    logic [N-1:0] exp_g[5];
    int           idx[$];
    exp_d = '{8'hA0, 8'hA1, 8'hA2, 8'hB0, 8'hB1};
    exp_g = '{4'b0001, 4'b0010, 4'b0100, 4'b0001, 4'b0010};
    do_reset();
    start_log();
    src_q[0].push_back({1'b1, 8'hA0}); src_q[0].push_back({1'b1, 8'hB0});
    src_q[1].push_back({1'b1, 8'hA1}); src_q[1].push_back({1'b1, 8'hB1});
    src_q[2].push_back({1'b1, 8'hA2});
    run(25);
    log_en = 1'b0;
    for (int t = 0; t < log_q.size(); t++) if (log_q[t].wen) idx.push_back(t);
    checks++;
    if (idx.size() != 5) begin
      errors++; $display("FAIL rr_count: got %0d writes expected 5", idx.size());
    end else begin
      for (int j = 0; j < 5; j++) begin
        checks++;
        if (log_q[idx[j]].din !== exp_d[j] || log_q[idx[j]].grant !== exp_g[j]) begin
          errors++; $display("FAIL rr_order%0d: got din=%h grant=%b expected din=%h grant=%b", j, log_q[idx[j]].din, log_q[idx[j]].grant, exp_d[j], exp_g[j]);
        end
        if (j > 0) begin
          checks++;
          if (idx[j] - idx[j-1] != 2) begin errors++; $display("FAIL rr_gap%0d: got %0d cycles expected 2", j, idx[j] - idx[j-1]); end
        end
      end
    end
  endtask

  task automatic test_full();
    logic [W-1:0] exp_d[4];
    int           idx[$];
    int           f0;
    bit           seen;
    exp_d = '{8'h31, 8'h32, 8'h33, 8'h34};
    start_log();
    src_q[1].push_back({1'b0, 8'h31}); src_q[1].push_back({1'b0, 8'h32});
    src_q[1].push_back({1'b0, 8'h33}); src_q[1].push_back({1'b1, 8'h34});
    seen = 1'b0;
    for (int n = 0; n < 20 && !seen; n++) begin
      run(1);
      if (log_q.size() > 0 && log_q[log_q.size()-1].wen) seen = 1'b1;
    end
    checks++;
    if (!seen) begin
      errors++; $display("FAIL full_first_write: got none expected a write within 20 cycles");
    end else begin
      full_force = 1'b1; fifo_full = 1'b1;
      f0 = log_q.size();
      repeat (5) @(posedge clk);
      full_force = 1'b0;
      run(8);
      log_en = 1'b0;
      for (int j = 0; j < 5; j++) begin
        checks++;
        if (log_q[f0+j].full !== 1'b1 || log_q[f0+j].ready !== '0 || log_q[f0+j].wen !== 1'b0 || log_q[f0+j].grant !== 4'b0010) begin
          errors++; $display("FAIL full_stall%0d: got full=%b ready=%b wen=%b grant=%b expected 1/0000/0/0010", j, log_q[f0+j].full, log_q[f0+j].ready, log_q[f0+j].wen, log_q[f0+j].grant);
        end
      end
      checks++;
      if (log_q[f0+5].wen !== 1'b1 || log_q[f0+5].din !== 8'h32) begin
        errors++; $display("FAIL full_resume: got wen=%b din=%h expected 1/32", log_q[f0+5].wen, log_q[f0+5].din);
      end
      for (int t = 0; t < log_q.size(); t++) if (log_q[t].wen) idx.push_back(t);
      checks++;
      if (idx.size() != 4) begin
        errors++; $display("FAIL full_count: got %0d writes expected 4", idx.size());
      end else begin
        for (int j = 0; j < 4; j++) begin
          checks++;
          if (log_q[idx[j]].din !== exp_d[j]) begin errors++; $display("FAIL full_byte%0d: got %h expected %h", j, log_q[idx[j]].din, exp_d[j]); end
        end
      end
    end
  endtask

  task automatic test_trunc();
    int idx[$];
    int ntrunc;
    start_log();
    for (int j = 0; j < 6; j++) src_q[2].push_back({(j == 5), W'(8'h81 + j)});
    run(18);
    log_en = 1'b0;
    ntrunc = 0;
    for (int t = 0; t < log_q.size(); t++) begin
      if (log_q[t].wen) idx.push_back(t);
      if (log_q[t].trunc === 1'b1) ntrunc++;
    end
    checks++;
    if (ntrunc != 1) begin errors++; $display("FAIL trunc_pulses: got %0d expected 1", ntrunc); end
    checks++;
    if (idx.size() != 6) begin
      errors++; $display("FAIL trunc_count: got %0d writes expected 6", idx.size());
    end else begin
      for (int j = 0; j < 6; j++) begin
        checks++;
        if (log_q[idx[j]].din !== W'(8'h81 + j) || log_q[idx[j]].trunc !== (j == 3)) begin
          errors++; $display("FAIL trunc_byte%0d: got din=%h trunc=%b expected din=%h trunc=%b", j, log_q[idx[j]].din, log_q[idx[j]].trunc, W'(8'h81 + j), (j == 3));
        end
      end
      checks++;
      if (log_q[idx[3]+1].grant !== '0) begin errors++; $display("FAIL trunc_release: got %b expected 0000", log_q[idx[3]+1].grant); end
      checks++;
      if (idx[4] - idx[3] != 2 || log_q[idx[4]].grant !== 4'b0100) begin
        errors++; $display("FAIL trunc_regrant: got gap=%0d grant=%b expected 2/0100", idx[4] - idx[3], log_q[idx[4]].grant);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [W-1:0] exp_d[4];
    logic [N-1:0] exp_g[4];
    int           idx[$];
    bit           seen;
    exp_d = '{8'h61, 8'h41, 8'h62, 8'h63};
    exp_g = '{4'b1000, 4'b0010, 4'b1000, 4'b1000};
    start_log();
    src_q[3].push_back({1'b0, 8'h61}); src_q[3].push_back({1'b0, 8'h62}); src_q[3].push_back({1'b1, 8'h63});
    seen = 1'b0;
    for (int n = 0; n < 20 && !seen; n++) begin
      run(1);
      if (log_q.size() > 0 && log_q[log_q.size()-1].wen) seen = 1'b1;
    end
    checks++;
    if (!seen) begin
      errors++; $display("FAIL rstmid_first_write: got none expected a write within 20 cycles");
    end else begin
      rst_n = 1'b0;
      #1;
      checks++;
      if (grant !== '0 || busy !== 1'b0 || fifo_wen !== 1'b0 || req_ready !== '0 || fifo_din !== '0 || trunc !== 1'b0) begin
        errors++; $display("FAIL rstmid_async: got grant=%b busy=%b wen=%b ready=%b din=%h trunc=%b expected all 0", grant, busy, fifo_wen, req_ready, fifo_din, trunc);
      end
      src_q[1].push_back({1'b1, 8'h41});
      repeat (2) @(posedge clk);
      #2 rst_n = 1'b1;
      run(14);
      log_en = 1'b0;
      for (int t = 0; t < log_q.size(); t++) if (log_q[t].wen) idx.push_back(t);
      checks++;
      if (idx.size() != 4) begin
        errors++; $display("FAIL rstmid_count: got %0d writes expected 4", idx.size());
      end else begin
        for (int j = 0; j < 4; j++) begin
          checks++;
          if (log_q[idx[j]].din !== exp_d[j] || log_q[idx[j]].grant !== exp_g[j]) begin
            errors++; $display("FAIL rstmid_order%0d: got din=%h grant=%b expected din=%h grant=%b", j, log_q[idx[j]].din, log_q[idx[j]].grant, exp_d[j], exp_g[j]);
          end
        end
      end
    end
  endtask

  // Random traffic checked against a packet-level model: each requester's
  // stream is pre-split into chunks (end at last or after MP beats), and the
  // model only tracks who owns the line and the round-robin pointer.
  task automatic test_random();
    int           len, cpos, mo, rr, e, k;
    bit           last, ends, drained;
    logic [W-1:0] d;
    logic [W+1:0] b;
    logic [N-1:0] eg, er;
    logic         ew;
    do_reset();
    start_log();
    for (int r = 0; r < N; r++) begin
      cpos = 0;
      for (int p = 0; p < 4; p++) begin
        len = int'($urandom_range(1, 7));
        for (int i = 0; i < len; i++) begin
          d = W'($urandom);
          last = (i == len - 1);
          ends = last || (cpos == MP - 1);
          src_q[r].push_back({last, d});
          exp_q[r].push_back({(cpos == MP - 1) && !last, ends, d});
          cpos = ends ? 0 : cpos + 1;
        end
      end
    end
    valid_pct = 70; full_pct = 20;
    drained = 1'b0;
    for (int n = 0; n < 4000 && !drained; n++) begin
      run(1);
      drained = 1'b1;
      for (int r = 0; r < N; r++) if (src_q[r].size() != 0) drained = 1'b0;
    end
    run(4);
    log_en = 1'b0;
    valid_pct = 100; full_pct = 0;
    checks++;
    if (!drained) begin errors++; $display("FAIL rnd_drain: got pending bytes expected all sent within 4000 cycles"); end
    mo = -1; rr = 0;
    for (int t = 0; t < log_q.size(); t++) begin
      eg = (mo < 0) ? '0 : N'(1) << mo;
      checks++;
      if (log_q[t].grant !== eg) begin errors++; $display("FAIL rnd_grant t=%0d: got %b expected %b", t, log_q[t].grant, eg); end
      if (mo < 0) begin
        checks++;
        if (log_q[t].wen !== 1'b0 || log_q[t].ready !== '0 || log_q[t].trunc !== 1'b0) begin
          errors++; $display("FAIL rnd_idle t=%0d: got wen=%b ready=%b trunc=%b expected 0", t, log_q[t].wen, log_q[t].ready, log_q[t].trunc);
        end
        e = -1;
        for (int i = N - 1; i >= 0; i--) begin
          k = (rr + i) % N;
          if (log_q[t].valid[k]) e = k;
        end
        mo = e;
      end else begin
        ew = log_q[t].valid[mo] && !log_q[t].full;
        er = log_q[t].full ? '0 : eg;
        checks++;
        if (log_q[t].wen !== ew || log_q[t].ready !== er) begin
          errors++; $display("FAIL rnd_hs t=%0d: got wen=%b ready=%b expected wen=%b ready=%b", t, log_q[t].wen, log_q[t].ready, ew, er);
        end
        if (ew) begin
          checks++;
          if (exp_q[mo].size() == 0) begin
            errors++; $display("FAIL rnd_extra t=%0d: got byte %h from req%0d expected none", t, log_q[t].din, mo);
          end else begin
            b = exp_q[mo].pop_front();
            if (log_q[t].din !== b[W-1:0] || log_q[t].trunc !== b[W+1]) begin
              errors++; $display("FAIL rnd_byte t=%0d: got din=%h trunc=%b expected din=%h trunc=%b", t, log_q[t].din, log_q[t].trunc, b[W-1:0], b[W+1]);
            end
            if (b[W]) begin rr = (mo + 1) % N; mo = -1; end
          end
        end else begin
          checks++;
          if (log_q[t].din !== '0 || log_q[t].trunc !== 1'b0) begin
            errors++; $display("FAIL rnd_noacc t=%0d: got din=%h trunc=%b expected 0/0", t, log_q[t].din, log_q[t].trunc);
          end
        end
      end
    end
    for (int r = 0; r < N; r++) begin
      checks++;
      if (exp_q[r].size() != 0) begin errors++; $display("FAIL rnd_left req%0d: got %0d unsent expected 0", r, exp_q[r].size()); end
    end
  endtask

`ifdef UART_ARB_ID_HDR_EN
  task automatic test_hdr();
    int idx[$];
    do_reset();
    start_log();
    src_q[2].push_back({1'b1, 8'h55});
    run(10);
    log_en = 1'b0;
    for (int t = 0; t < log_q.size(); t++) if (log_q[t].wen) idx.push_back(t);
    checks++;
    if (idx.size() != 2) begin
      errors++; $display("FAIL hdr_count: got %0d writes expected 2", idx.size());
    end else begin
      checks++;
      if (log_q[idx[0]].din !== 8'h02 || log_q[idx[0]].ready !== '0) begin
        errors++; $display("FAIL hdr_id: got din=%h ready=%b expected 02/0000", log_q[idx[0]].din, log_q[idx[0]].ready);
      end
      checks++;
      if (log_q[idx[1]].din !== 8'h55 || idx[1] - idx[0] != 1) begin
        errors++; $display("FAIL hdr_data: got din=%h gap=%0d expected 55/1", log_q[idx[1]].din, idx[1] - idx[0]);
      end
    end
  endtask
`endif

  initial begin : main
    test_reset();
`ifdef UART_ARB_ID_HDR_EN
    test_hdr();
`else
    test_single();
    test_rr();
    test_full();
    test_trunc();
    test_reset_mid();
    test_random();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Packet-level round-robin arbiter sharing one UART transmit path (TX FIFO write port plus serializer) between NUM_REQ byte-stream requesters.
- Each requester presents a valid/ready byte stream with a last flag marking the end of a packet.
- The arbiter grants one requester per packet and forwards its bytes to the FIFO write port, honouring FIFO full, so packets never interleave on the serial line.
- Sits between the requesters and the UART TX FIFO write interface (tx_wen_i/din_i/full_o).

Parameters:
- NUM_REQ, 4: number of requesters; 2..16.
- DATA_WIDTH, 8: byte width; must equal the UART TX data width.
- MAX_PKT, 64: maximum beats per grant before forced release; >= 2.

Ports:
- clk_i  input  1  system clock, all logic on rising edge.
- rst_ni  input  1  asynchronous active-low reset.
- req_valid_i  input  NUM_REQ  per-requester byte valid.
- req_data_i  input  NUM_REQ*DATA_WIDTH  per-requester byte; requester k occupies bits [k*DATA_WIDTH +: DATA_WIDTH].
- req_last_i  input  NUM_REQ  per-requester final byte of packet; qualified by valid.
- req_ready_o  output  NUM_REQ  per-requester byte accepted when valid&&ready.
- fifo_full_i  input  1  UART TX FIFO full.
- fifo_wen_o  output  1  FIFO write enable.
- fifo_din_o  output  DATA_WIDTH  FIFO write data.
- grant_o  output  NUM_REQ  one-hot current owner; all zero when idle.
- busy_o  output  1  a grant is active.
- trunc_o  output  1  one-cycle pulse when a grant is force-released at MAX_PKT.

Behaviour:
- Reset (async assert, sync release): state IDLE, rr pointer 0, beat count 0. Outputs: grant_o=0, busy_o=0, trunc_o=0, fifo_wen_o=0, req_ready_o=0, fifo_din_o=0.
- States: IDLE, HDR (only with the optional feature), XFER.
- IDLE:
  - req_ready_o=0, fifo_wen_o=0.
  - If any req_valid_i is set, select the first set bit searching upward from the rr pointer with wrap-around. Register the selection into grant_o, clear the beat count, and go to XFER (or HDR).
  - Arbitration latency is 1 cycle. There is a minimum of 1 IDLE cycle between packets.
- XFER, with owner g:
  - req_ready_o[g] = !fifo_full_i; all other ready bits are 0.
  - fifo_wen_o = req_valid_i[g] && !fifo_full_i (combinational).
  - fifo_din_o = req_data_i[g]; it is 0 whenever fifo_wen_o=0.
  - Each accepted beat increments the beat count.
  - Accepted beat with req_last_i[g]=1: go to IDLE, rr pointer = (g+1) mod NUM_REQ, grant_o cleared next cycle.
  - Accepted beat without last when beat count == MAX_PKT-1: same release as a last beat, plus trunc_o pulses for 1 cycle. The requester's remaining bytes are arbitrated as a new packet.
  - No accepted beat (valid low or FIFO full): hold the grant indefinitely.
- Data never leaves a requester unless both its ready and valid are high. No byte is dropped or duplicated.
- A requester deasserting valid mid-packet stalls the arbiter while keeping the grant. Other requesters wait.
- fifo_full_i asserted on a beat cycle: no write and no ready. Resume on the first cycle it is low.
- Reset mid-packet: immediate return to IDLE. Partially sent FIFO contents are the FIFO's concern.
- Beat counter width is $clog2(MAX_PKT+1) bits and never wraps.

Optional Feature:
- Macro: UART_ARB_ID_HDR_EN.
- Defined:
  - After grant, enter HDR.
  - In HDR, fifo_wen_o = !fifo_full_i and fifo_din_o = owner index g, zero-extended to DATA_WIDTH. All req_ready_o are 0.
  - On the write, go to XFER. The header does not count toward MAX_PKT.
  - Elaboration error if DATA_WIDTH < $clog2(NUM_REQ).
- Undefined: the HDR state, its logic and the check are absent. IDLE goes straight to XFER.

Test Plan:
- Reset, then req0 sends 3 bytes 0x11,0x22,0x33 (last on 0x33), FIFO never full -> grant_o=0001 one cycle after valid. fifo_wen_o high 3 consecutive cycles with data 0x11,0x22,0x33. grant_o=0 after the last byte.
- Requesters 0,1,2 request simultaneously with 1-byte packets 0xA0,0xA1,0xA2 -> FIFO receives 0xA0,0xA1,0xA2 in that order. The next round starting at req3 (idle) then req0 keeps round-robin order.
- fifo_full_i high for 5 cycles mid-packet from req1 -> req_ready_o and fifo_wen_o are 0 for those 5 cycles. The packet resumes with no lost or duplicated byte.
- MAX_PKT=4, req2 streams 6 bytes with last only on the 6th -> trunc_o pulses on the 4th accepted byte. The grant is released, and the remaining 2 bytes arrive as a new grant.
- Assert rst_ni low while req3 is mid-packet -> all outputs 0 asynchronously. After release the rr pointer is 0 and req3's next byte starts a fresh grant.
- With UART_ARB_ID_HDR_EN, req2 sends 0x55 (last) -> FIFO receives 0x02 then 0x55.
